// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, ALU selects, controller states and the
// per-step control vector used by control_unit, main1 and the ALU.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [3:0] ALU_NONE  = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_SHR   = 4'b0011;
    localparam logic [3:0] ALU_SHL   = 4'b0100;
    localparam logic [3:0] ALU_ROR   = 4'b0101;
    localparam logic [3:0] ALU_AND   = 4'b0110;
    localparam logic [3:0] ALU_OR    = 4'b0111;
    localparam logic [3:0] ALU_ROL   = 4'b1000;
    localparam logic [3:0] ALU_INCPC = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;
    localparam logic [3:0] ALU_NEG   = 4'b1100;
    localparam logic [3:0] ALU_NOT   = 4'b1101;

    typedef enum logic [3:0] {
        RESET_ST = 4'd0,
        T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
        T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8,
        HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic rin, rout, hi_in, lo_in, pc_in, ir_in, y_in, in_port_out;
        logic z_in, con_in, out_port_in, r15_ctrl, hi_out, lo_out, pc_out;
        logic mdr_out, mdr_in, mar_in, mdr_read, mem_write, cout, inc_pc;
        logic z_low_out, z_high_out, con_out, ba_out, gra, grb, grc;
        logic [3:0] alu_select;
    } ctrl_t;

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_NONE;
        endcase
    endfunction

    // Final step of each instruction; nop, halt and undefined opcodes end at fetch.
    function automatic state_t last_step(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST:                           return T7;
            OP_MUL, OP_DIV, OP_BR:                  return T6;
            OP_NEG, OP_NOT, OP_JAL:                 return T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return T3;
            OP_NOP, OP_HALT:                        return T2;
            default:                                return (op > OP_HALT) ? T2 : T5;
        endcase
    endfunction

    function automatic state_t step_after(input state_t s);
        case (s)
            T0:      return T1;
            T1:      return T2;
            T2:      return T3;
            T3:      return T4;
            T4:      return T5;
            T5:      return T6;
            T6:      return T7;
            default: return T0;
        endcase
    endfunction

endpackage

// File: rtl/step_decoder.sv
// Pure combinational map from (state, opcode) to the main1 control vector.
module step_decoder
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1;
                ctrl.z_in = 1'b1; ctrl.alu_select = ALU_INCPC;
            end
            T1: begin
                ctrl.z_low_out = 1'b1; ctrl.pc_in = 1'b1;
                ctrl.mdr_read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            T3, T4, T5, T6, T7: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state)
                            T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.cout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_select = ALU_ADD; end
                            T5: begin
                                ctrl.z_low_out = 1'b1;
                                if (opcode == OP_LDI) begin
                                    ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                                end else begin
                                    ctrl.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                if (opcode == OP_LD) begin
                                    ctrl.mdr_read = 1'b1; ctrl.mdr_in = 1'b1;
                                end else if (opcode == OP_ST) begin
                                    ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdr_in = 1'b1;
                                end
                            end
                            T7: begin
                                if (opcode == OP_LD) begin
                                    ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                                end else if (opcode == OP_ST) begin
                                    ctrl.mdr_out = 1'b1; ctrl.mem_write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin
                                ctrl.z_in = 1'b1; ctrl.alu_select = alu_code(opcode);
                                if (opcode inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
                                    ctrl.cout = 1'b1;
                                end else begin
                                    ctrl.grc = 1'b1; ctrl.rout = 1'b1;
                                end
                            end
                            T5: begin ctrl.z_low_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state)
                            T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin
                                ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1;
                                ctrl.alu_select = alu_code(opcode);
                            end
                            T5: begin ctrl.z_low_out = 1'b1; ctrl.lo_in = 1'b1; end
                            T6: begin ctrl.z_high_out = 1'b1; ctrl.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state)
                            T3: begin
                                ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1;
                                ctrl.alu_select = alu_code(opcode);
                            end
                            T4: begin ctrl.z_low_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    // PC load in T6 is qualified by main1's CON flip-flop, not here.
                    OP_BR: begin
                        case (state)
                            T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_in = 1'b1; end
                            T4: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                            T5: begin ctrl.cout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_select = ALU_ADD; end
                            T6: begin ctrl.z_low_out = 1'b1; ctrl.con_out = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_JAL: begin
                        case (state)
                            T3: begin ctrl.r15_ctrl = 1'b1; ctrl.pc_out = 1'b1; end
                            T4: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_JR:   if (state == T3) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1; end
                    OP_IN:   if (state == T3) begin ctrl.gra = 1'b1; ctrl.rin = 1'b1; ctrl.in_port_out = 1'b1; end
                    OP_OUT:  if (state == T3) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.out_port_in = 1'b1; end
                    OP_MFHI: if (state == T3) begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    OP_MFLO: if (state == T3) begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore controller for main1: fetch T0-T2, opcode-driven execute
// steps, halt handling. Outputs depend only on the state register and IR.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] IR,
    output logic        Run,
    output logic        Rin, Rout, HIin, LOin, PCin, IRin, Yin, InPortout,
    output logic        Zin, conIn, outPortin, R15ctrl, HIout, LOout, PCout,
    output logic        MDRout, MDRin, MARin, MDRread, memWrite, Cout, IncPC,
    output logic        ZLowout, ZHighout, conOut, BAout, Gra, Grb, Grc,
    output logic [3:0]  ALUselect
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RESET_ST;
        else       state <= next_state;
    end

    // last_step never returns T0/T1, so the not-yet-loaded IR cannot steer fetch.
    always_comb begin
        next_state = state;
        case (state)
            RESET_ST: next_state = T0;
            HALT:     next_state = HALT;
            default: begin
                if (state == last_step(opcode)) begin
                    if (opcode == OP_HALT || stop) next_state = HALT;
                    else                           next_state = T0;
                end else begin
                    next_state = step_after(state);
                end
            end
        endcase
    end

    step_decoder u_step_decoder (
        .state  (state),
        .opcode (opcode),
        .ctrl   (ctrl)
    );

    assign Run       = (state != RESET_ST) && (state != HALT);
    assign Rin       = ctrl.rin;
    assign Rout      = ctrl.rout;
    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign PCin      = ctrl.pc_in;
    assign IRin      = ctrl.ir_in;
    assign Yin       = ctrl.y_in;
    assign InPortout = ctrl.in_port_out;
    assign Zin       = ctrl.z_in;
    assign conIn     = ctrl.con_in;
    assign outPortin = ctrl.out_port_in;
    assign R15ctrl   = ctrl.r15_ctrl;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign PCout     = ctrl.pc_out;
    assign MDRout    = ctrl.mdr_out;
    assign MDRin     = ctrl.mdr_in;
    assign MARin     = ctrl.mar_in;
    assign MDRread   = ctrl.mdr_read;
    assign memWrite  = ctrl.mem_write;
    assign Cout      = ctrl.cout;
    assign IncPC     = ctrl.inc_pc;
    assign ZLowout   = ctrl.z_low_out;
    assign ZHighout  = ctrl.z_high_out;
    assign conOut    = ctrl.con_out;
    assign BAout     = ctrl.ba_out;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign ALUselect = ctrl.alu_select;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a step-table model queues the expected
// output vector per cycle; a monitor pops and compares at each falling edge.
`timescale 1ns/1ps
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stop = 1'b0;
    logic [31:0] IR = 32'h0;
    logic Run, Rin, Rout, HIin, LOin, PCin, IRin, Yin, InPortout, Zin, conIn, outPortin;
    logic R15ctrl, HIout, LOout, PCout, MDRout, MDRin, MARin, MDRread, memWrite, Cout;
    logic IncPC, ZLowout, ZHighout, conOut, BAout, Gra, Grb, Grc;
    logic [3:0] ALUselect;

    control_unit dut (
        .clk(clk), .reset(reset), .stop(stop), .IR(IR), .Run(Run),
        .Rin(Rin), .Rout(Rout), .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin),
        .Yin(Yin), .InPortout(InPortout), .Zin(Zin), .conIn(conIn), .outPortin(outPortin),
        .R15ctrl(R15ctrl), .HIout(HIout), .LOout(LOout), .PCout(PCout), .MDRout(MDRout),
        .MDRin(MDRin), .MARin(MARin), .MDRread(MDRread), .memWrite(memWrite), .Cout(Cout),
        .IncPC(IncPC), .ZLowout(ZLowout), .ZHighout(ZHighout), .conOut(conOut),
        .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALUselect(ALUselect)
    );

    always #5 clk = ~clk;

    typedef logic [33:0] vec_t;
    localparam int RIN = 0,  ROUT = 1,  HIIN = 2,  LOIN = 3,  PCIN = 4,  IRIN = 5;
    localparam int YIN = 6,  INPO = 7,  ZIN = 8,  CONIN = 9, OUTPI = 10, R15 = 11;
    localparam int HIOUT = 12, LOOUT = 13, PCOUT = 14, MDROUT = 15, MDRIN = 16;
    localparam int MARIN = 17, MDRRD = 18, MEMWR = 19, COUT = 20, INCPC = 21;
    localparam int ZLOW = 22, ZHIGH = 23, CONOUT = 24, BAOUT = 25, GRA = 26, GRB = 27, GRC = 28;
    localparam int RUN = 33;

    vec_t got;
    assign got = {Run, ALUselect, Grc, Grb, Gra, BAout, conOut, ZHighout, ZLowout, IncPC,
                  Cout, memWrite, MDRread, MARin, MDRin, MDRout, PCout, LOout, HIout,
                  R15ctrl, outPortin, conIn, Zin, InPortout, Yin, IRin, PCin, LOin, HIin,
                  Rout, Rin};

    vec_t sb[$];
    vec_t prog[$];
    int   checks = 0;
    int   fails = 0;

    function automatic vec_t b(input int i);
        return vec_t'(1) << i;
    endfunction

    function automatic vec_t st(input vec_t sigs, input int alu);
        return sigs | (vec_t'(alu) << 29) | b(RUN);
    endfunction

    function automatic int alu_of(input int op);
        case (op)
            3, 11:   return 1;
            4:       return 2;
            5:       return 3;
            6:       return 4;
            7:       return 5;
            8:       return 8;
            9, 12:   return 6;
            10, 13:  return 7;
            14:      return 10;
            15:      return 11;
            16:      return 12;
            17:      return 13;
            default: return 0;
        endcase
    endfunction

    function automatic void check(input string name, input vec_t g, input vec_t e);
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, g, e);
        end
    endfunction

    // Reference model: the step list for one instruction, T0 to its last step.
    task automatic expand(input int op);
        prog.delete();
        prog.push_back(st(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN), 9));
        prog.push_back(st(b(ZLOW) | b(PCIN) | b(MDRRD) | b(MDRIN), 0));
        prog.push_back(st(b(MDROUT) | b(IRIN), 0));
        if (op <= 2) begin
            prog.push_back(st(b(GRB) | b(BAOUT) | b(YIN), 0));
            prog.push_back(st(b(COUT) | b(ZIN), 1));
            if (op == 1) prog.push_back(st(b(ZLOW) | b(GRA) | b(RIN), 0));
            else begin
                prog.push_back(st(b(ZLOW) | b(MARIN), 0));
                if (op == 0) begin
                    prog.push_back(st(b(MDRRD) | b(MDRIN), 0));
                    prog.push_back(st(b(MDROUT) | b(GRA) | b(RIN), 0));
                end else begin
                    prog.push_back(st(b(GRA) | b(ROUT) | b(MDRIN), 0));
                    prog.push_back(st(b(MDROUT) | b(MEMWR), 0));
                end
            end
        end else if (op <= 13) begin
            prog.push_back(st(b(GRB) | b(ROUT) | b(YIN), 0));
            if (op <= 10) prog.push_back(st(b(GRC) | b(ROUT) | b(ZIN), alu_of(op)));
            else          prog.push_back(st(b(COUT) | b(ZIN), alu_of(op)));
            prog.push_back(st(b(ZLOW) | b(GRA) | b(RIN), 0));
        end else if (op <= 15) begin
            prog.push_back(st(b(GRA) | b(ROUT) | b(YIN), 0));
            prog.push_back(st(b(GRB) | b(ROUT) | b(ZIN), alu_of(op)));
            prog.push_back(st(b(ZLOW) | b(LOIN), 0));
            prog.push_back(st(b(ZHIGH) | b(HIIN), 0));
        end else if (op <= 17) begin
            prog.push_back(st(b(GRB) | b(ROUT) | b(ZIN), alu_of(op)));
            prog.push_back(st(b(ZLOW) | b(GRA) | b(RIN), 0));
        end else begin
            case (op)
                18: begin
                    prog.push_back(st(b(GRA) | b(ROUT) | b(CONIN), 0));
                    prog.push_back(st(b(PCOUT) | b(YIN), 0));
                    prog.push_back(st(b(COUT) | b(ZIN), 1));
                    prog.push_back(st(b(ZLOW) | b(CONOUT), 0));
                end
                19: prog.push_back(st(b(GRA) | b(ROUT) | b(PCIN), 0));
                20: begin
                    prog.push_back(st(b(R15) | b(PCOUT), 0));
                    prog.push_back(st(b(GRA) | b(ROUT) | b(PCIN), 0));
                end
                21: prog.push_back(st(b(GRA) | b(RIN) | b(INPO), 0));
                22: prog.push_back(st(b(GRA) | b(ROUT) | b(OUTPI), 0));
                23: prog.push_back(st(b(HIOUT) | b(GRA) | b(RIN), 0));
                24: prog.push_back(st(b(LOOUT) | b(GRA) | b(RIN), 0));
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset mid-cycle: outputs must clear before any further clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_async", got, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            stop = 1'($urandom_range(0, 1));
            IR   = $urandom;
            sb.push_back('0);
        end
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ir, input bit stop_last, input int abort_at);
        int op;
        int n;
        op = int'(ir[31:27]);
        expand(op);
        n = prog.size();
        for (int k = 0; k < n; k++) begin
            tick();
            IR   = (k < 2) ? $urandom : ir;
            stop = (k == n - 1) ? stop_last : 1'($urandom_range(0, 1));
            sb.push_back(prog[k]);
            if (k == abort_at) begin
                do_reset();
                return;
            end
        end
        if (op == 26 || stop_last) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                stop = 1'($urandom_range(0, 1));
                IR   = $urandom;
                sb.push_back('0);
            end
            do_reset();
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) check("step", got, sb.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir;
        int abort_at;
        do_reset();
        run_instr(32'h08800055, 1'b0, -1);
        run_instr(32'h1080005A, 1'b0, -1);
        run_instr(32'h91000023, 1'b0, -1);
        run_instr(32'hA0800000, 1'b0, -1);
        run_instr(32'h591FFFFB, 1'b1, -1);
        run_instr(32'hD0000000, 1'b0, -1);
        run_instr(32'h00800055, 1'b0, 6);
        run_instr(32'hC8000000, 1'b0, -1);
        for (int i = 0; i < 150; i++) begin
            ir = $urandom;
            abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(ir, $urandom_range(0, 9) == 0, abort_at);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
